// File: rtl/ysyx_25020047_wbu_stage.sv
// Write-back stage: builds the commit record (rf write, next PC, error) at enqueue and holds it in a 2-entry skid FIFO.
// Optional retired-instruction counter is enabled by defining YSYX_25020047_WBU_RETCNT_EN.
module ysyx_25020047_wbu_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_wbsel,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_memdata,
    input  logic [XLEN-1:0] in_snpc,
    input  logic            in_taken,
    input  logic [RA_W-1:0] in_rd,
    input  logic [1:0]      in_lsize,
    input  logic            in_lsign,
    input  logic [2:0]      in_addr_lo,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_dnpc,
    output logic            out_err,
    output logic            rf_wen,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata
`ifdef YSYX_25020047_WBU_RETCNT_EN
    ,
    output logic [63:0]     retired_cnt
`endif
);

    localparam logic [2:0] WB_NONE   = 3'd0;
    localparam logic [2:0] WB_ALU    = 3'd1;
    localparam logic [2:0] WB_LOAD   = 3'd2;
    localparam logic [2:0] WB_JUMP   = 3'd3;
    localparam logic [2:0] WB_BRANCH = 3'd4;

    typedef struct packed {
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] dnpc;
        logic [RA_W-1:0] rd;
        logic            wen;
        logic            err;
    } rec_t;

    // ---------------- load alignment / extension ----------------
    logic [2:0]      ld_off;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_ext;
    logic            ld_misalign;
    int              ld_msb;

    always_comb begin
        // Byte offset inside the naturally aligned memory word
        ld_off   = (XLEN == 64) ? in_addr_lo : {1'b0, in_addr_lo[1:0]};
        ld_shift = in_memdata >> {ld_off, 3'b000};
        case (in_lsize)
            2'd0:    ld_msb = 7;
            2'd1:    ld_msb = 15;
            2'd2:    ld_msb = 31;
            default: ld_msb = XLEN - 1;
        endcase
        ld_ext = ld_shift;
        for (int i = 0; i < XLEN; i++) begin
            if (i > ld_msb) begin
                ld_ext[i] = in_lsign & ld_shift[ld_msb];
            end
        end
        case (in_lsize)
            2'd0:    ld_misalign = 1'b0;
            2'd1:    ld_misalign = in_addr_lo[0];
            2'd2:    ld_misalign = (in_addr_lo[1:0] != 2'd0);
            default: ld_misalign = (XLEN == 32) || (in_addr_lo != 3'd0);
        endcase
    end

    // ---------------- record construction ----------------
    rec_t rec_d;

    always_comb begin
        rec_d.wdata = in_result;
        rec_d.dnpc  = in_snpc;
        rec_d.rd    = in_rd;
        rec_d.wen   = 1'b0;
        rec_d.err   = 1'b0;
        case (in_wbsel)
            WB_NONE: ;
            WB_ALU: rec_d.wen = 1'b1;
            WB_LOAD: begin
                if (ld_misalign) begin
                    rec_d.err = 1'b1;
                end else begin
                    rec_d.wdata = ld_ext;
                    rec_d.wen   = 1'b1;
                end
            end
            WB_JUMP: begin
                rec_d.wdata = in_snpc;
                rec_d.wen   = 1'b1;
                rec_d.dnpc  = {in_result[XLEN-1:1], 1'b0};
            end
            WB_BRANCH: begin
                if (in_taken) begin
                    rec_d.dnpc = in_result;
                end
            end
            default: rec_d.err = 1'b1;
        endcase
        // x0 is never written; this is not an error
        if (in_rd == '0) begin
            rec_d.wen = 1'b0;
        end
    end

    // ---------------- 2-entry FIFO ----------------
    rec_t       fifo_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       in_ready_q;
    logic       push;
    logic       pop;
    rec_t       head;

    assign head      = fifo_q[rd_ptr_q];
    assign out_valid = (count_q != 2'd0);
    assign in_ready  = in_ready_q;
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            // Registered so upstream ready never depends on out_ready
            in_ready_q <= (count_d != 2'd2);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= rec_d;
        end
    end

    assign out_dnpc = out_valid ? head.dnpc  : '0;
    assign out_err  = out_valid ? head.err   : 1'b0;
    assign rf_waddr = out_valid ? head.rd    : '0;
    assign rf_wdata = out_valid ? head.wdata : '0;
    assign rf_wen   = pop & head.wen;

`ifdef YSYX_25020047_WBU_RETCNT_EN
    logic [63:0] retired_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= 64'd0;
        end else if (pop && !head.err) begin
            retired_q <= retired_q + 64'd1;
        end
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_ysyx_25020047_wbu_stage.sv
// Self-checking bench for ysyx_25020047_wbu_stage: directed scenarios plus randomized traffic against a queue model.
module tb_ysyx_25020047_wbu_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_wbsel;
    logic [31:0] in_result;
    logic [31:0] in_memdata;
    logic [31:0] in_snpc;
    logic        in_taken;
    logic [4:0]  in_rd;
    logic [1:0]  in_lsize;
    logic        in_lsign;
    logic [2:0]  in_addr_lo;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dnpc;
    logic        out_err;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef YSYX_25020047_WBU_RETCNT_EN
    logic [63:0] retired_cnt;
`endif

    ysyx_25020047_wbu_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wbsel   (in_wbsel),
        .in_result  (in_result),
        .in_memdata (in_memdata),
        .in_snpc    (in_snpc),
        .in_taken   (in_taken),
        .in_rd      (in_rd),
        .in_lsize   (in_lsize),
        .in_lsign   (in_lsign),
        .in_addr_lo (in_addr_lo),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dnpc   (out_dnpc),
        .out_err    (out_err),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
`ifdef YSYX_25020047_WBU_RETCNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] dnpc;
        logic [4:0]  rd;
        logic        wen;
        logic        err;
    } exp_t;

    exp_t        mq[$];
    logic [63:0] ret_model;
    int          checks = 0;
    int          errors = 0;

    // Reference record derived directly from the op-class rules
    function automatic exp_t model_rec();
        exp_t        r;
        logic [31:0] w;
        int          off;
        r.rd    = in_rd;
        r.dnpc  = in_snpc;
        r.wdata = 32'h0;
        r.wen   = 1'b0;
        r.err   = 1'b0;
        case (in_wbsel)
            3'd0: ;
            3'd1: begin r.wdata = in_result; r.wen = 1'b1; end
            3'd2: begin
                if (in_lsize == 2'd3 || (in_lsize == 2'd2 && in_addr_lo[1:0] != 2'd0) ||
                    (in_lsize == 2'd1 && in_addr_lo[0])) begin
                    r.err = 1'b1;
                end else begin
                    off = int'(in_addr_lo[1:0]);
                    w = in_memdata >> (8 * off);
                    if (in_lsize == 2'd0) begin
                        w = w & 32'hFF;
                        if (in_lsign && w[7]) w = w | 32'hFFFF_FF00;
                    end else if (in_lsize == 2'd1) begin
                        w = w & 32'hFFFF;
                        if (in_lsign && w[15]) w = w | 32'hFFFF_0000;
                    end
                    r.wdata = w;
                    r.wen   = 1'b1;
                end
            end
            3'd3: begin r.wdata = in_snpc; r.wen = 1'b1; r.dnpc = in_result & 32'hFFFF_FFFE; end
            3'd4: if (in_taken) r.dnpc = in_result;
            default: r.err = 1'b1;
        endcase
        if (in_rd == 5'd0) r.wen = 1'b0;
        return r;
    endfunction

    task automatic drive_idle();
        in_valid   = 1'b0;
        in_wbsel   = 3'd0;
        in_result  = 32'h0;
        in_memdata = 32'h0;
        in_snpc    = 32'h0;
        in_taken   = 1'b0;
        in_rd      = 5'd0;
        in_lsize   = 2'd0;
        in_lsign   = 1'b0;
        in_addr_lo = 3'd0;
    endtask

    task automatic drive(input logic [2:0] wbsel, input logic [31:0] result, input logic [31:0] memdata,
                         input logic [31:0] snpc, input logic taken, input logic [4:0] rd,
                         input logic [1:0] lsize, input logic lsign, input logic [2:0] addr_lo);
        in_valid   = 1'b1;
        in_wbsel   = wbsel;
        in_result  = result;
        in_memdata = memdata;
        in_snpc    = snpc;
        in_taken   = taken;
        in_rd      = rd;
        in_lsize   = lsize;
        in_lsign   = lsign;
        in_addr_lo = addr_lo;
    endtask

    // Advance one clock, updating the model with the handshakes that occur at this edge
    task automatic clk_step();
        bit   push;
        bit   pop;
        exp_t h;
        push = rst_n && in_valid && (mq.size() < 2);
        pop  = rst_n && (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            ret_model = 64'd0;
        end else begin
            if (pop) begin
                h = mq.pop_front();
                if (!h.err) ret_model = ret_model + 64'd1;
            end
            if (push) mq.push_back(model_rec());
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive_idle();
        clk_step();
        clk_step();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%h exp=1", in_ready); end
        checks++; if (out_dnpc !== 32'h0) begin errors++; $display("FAIL reset_dnpc got=%h exp=0", out_dnpc); end
        checks++; if (rf_waddr !== 5'h0 || rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_rf got=%h/%h exp=0/0", rf_waddr, rf_wdata); end
        checks++; if (out_err !== 1'b0 || rf_wen !== 1'b0) begin errors++; $display("FAIL reset_err_wen got=%h/%h exp=0/0", out_err, rf_wen); end
`ifdef YSYX_25020047_WBU_RETCNT_EN
        checks++; if (retired_cnt !== 64'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired_cnt); end
`endif
        rst_n = 1'b1;
        clk_step();
    endtask

    task automatic test_alu();
        out_ready = 1'b1;
        drive(3'd1, 32'h1234, 32'h0, 32'h8000_0004, 1'b0, 5'd5, 2'd0, 1'b0, 3'd0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_in_ready got=%h exp=1", in_ready); end
        clk_step();
        drive_idle();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got=%h exp=1", out_valid); end
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL alu_wen got=%h exp=1", rf_wen); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got=%0d exp=5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL alu_wdata got=%h exp=00001234", rf_wdata); end
        checks++; if (out_dnpc !== 32'h8000_0004) begin errors++; $display("FAIL alu_dnpc got=%h exp=80000004", out_dnpc); end
        clk_step();
    endtask

    task automatic test_load();
        logic [1:0]  sz [3] = '{2'd0, 2'd0, 2'd1};
        logic        sg [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0]  ad [3] = '{3'd2, 3'd1, 3'd2};
        logic [31:0] ex [3] = '{32'hFFFF_FFFF, 32'h0000_007F, 32'hFFFF_80FF};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(3'd2, 32'h0, 32'h80FF_7F01, 32'h8000_0100, 1'b0, 5'd7, sz[k], sg[k], ad[k]);
            clk_step();
            drive_idle();
            #1;
            checks++; if (rf_wdata !== ex[k] || rf_wen !== 1'b1) begin errors++; $display("FAIL load%0d got=%h wen=%h exp=%h wen=1", k, rf_wdata, rf_wen, ex[k]); end
            clk_step();
        end
    endtask

    task automatic test_jump_branch();
        out_ready = 1'b1;
        drive(3'd3, 32'h8000_0103, 32'h0, 32'h8000_0010, 1'b0, 5'd1, 2'd0, 1'b0, 3'd0);
        clk_step();
        drive(3'd4, 32'h8000_0200, 32'h0, 32'h8000_0014, 1'b0, 5'd3, 2'd0, 1'b0, 3'd0);
        #1;
        checks++; if (out_dnpc !== 32'h8000_0102) begin errors++; $display("FAIL jump_dnpc got=%h exp=80000102", out_dnpc); end
        checks++; if (rf_wdata !== 32'h8000_0010 || rf_wen !== 1'b1) begin errors++; $display("FAIL jump_wdata got=%h wen=%h exp=80000010 wen=1", rf_wdata, rf_wen); end
        clk_step();
        drive(3'd4, 32'h8000_0200, 32'h0, 32'h8000_0018, 1'b1, 5'd3, 2'd0, 1'b0, 3'd0);
        #1;
        checks++; if (out_dnpc !== 32'h8000_0014 || rf_wen !== 1'b0) begin errors++; $display("FAIL branch_nt got=%h wen=%h exp=80000014 wen=0", out_dnpc, rf_wen); end
        clk_step();
        drive_idle();
        #1;
        checks++; if (out_dnpc !== 32'h8000_0200 || rf_wen !== 1'b0) begin errors++; $display("FAIL branch_t got=%h wen=%h exp=80000200 wen=0", out_dnpc, rf_wen); end
        clk_step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(3'd1, 32'h100 + k, 32'h0, 32'h10 + 4 * k, 1'b0, 5'(10 + k), 2'd0, 1'b0, 3'd0);
            #1;
            checks++; if (in_ready !== (k < 2)) begin errors++; $display("FAIL bp_in_ready%0d got=%h exp=%h", k, in_ready, (k < 2)); end
            clk_step();
        end
        drive_idle();
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_full got=%h/%h exp=0/1", in_ready, out_valid); end
        checks++; if (rf_wdata !== 32'h100 || rf_wen !== 1'b0) begin errors++; $display("FAIL bp_stall_hold got=%h wen=%h exp=100 wen=0", rf_wdata, rf_wen); end
        out_ready = 1'b1;
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_wdata !== 32'h100 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_first got=%h wen=%h rdy=%h exp=100 wen=1 rdy=0", rf_wdata, rf_wen, in_ready); end
        clk_step();
        #1;
        checks++; if (in_ready !== 1'b1 || rf_wdata !== 32'h101 || rf_waddr !== 5'd11) begin errors++; $display("FAIL bp_second got=%h rd=%0d rdy=%h exp=101 rd=11 rdy=1", rf_wdata, rf_waddr, in_ready); end
        clk_step();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_third_dropped got=%h exp=0", out_valid); end
    endtask

    task automatic test_errors();
        logic [63:0] ret_before;
        ret_before = ret_model;
        out_ready = 1'b1;
        drive(3'd6, 32'h55, 32'h0, 32'h8000_0040, 1'b0, 5'd4, 2'd0, 1'b0, 3'd0);
        clk_step();
        drive(3'd2, 32'h0, 32'h1234_5678, 32'h8000_0044, 1'b0, 5'd4, 2'd1, 1'b1, 3'd3);
        #1;
        checks++; if (out_err !== 1'b1 || rf_wen !== 1'b0 || out_dnpc !== 32'h8000_0040) begin errors++; $display("FAIL err_reserved got err=%h wen=%h dnpc=%h exp err=1 wen=0 dnpc=80000040", out_err, rf_wen, out_dnpc); end
        clk_step();
        drive(3'd1, 32'h77, 32'h0, 32'h8000_0048, 1'b0, 5'd0, 2'd0, 1'b0, 3'd0);
        #1;
        checks++; if (out_err !== 1'b1 || rf_wen !== 1'b0 || out_dnpc !== 32'h8000_0044) begin errors++; $display("FAIL err_misalign got err=%h wen=%h dnpc=%h exp err=1 wen=0 dnpc=80000044", out_err, rf_wen, out_dnpc); end
        clk_step();
        drive_idle();
        #1;
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || rf_wen !== 1'b0) begin errors++; $display("FAIL err_rd0 got v=%h err=%h wen=%h exp v=1 err=0 wen=0", out_valid, out_err, rf_wen); end
        clk_step();
`ifdef YSYX_25020047_WBU_RETCNT_EN
        #1;
        checks++; if (retired_cnt !== ret_before + 64'd1) begin errors++; $display("FAIL err_retired got=%0d exp=%0d", retired_cnt, ret_before + 64'd1); end
`endif
        checks++; if (ret_model !== ret_before + 64'd1) begin errors++; $display("FAIL err_model_retired got=%0d exp=%0d", ret_model, ret_before + 64'd1); end
    endtask

    task automatic test_random();
        exp_t h;
        for (int c = 0; c < 400; c++) begin
            drive(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%h exp=%h", c, out_valid, (mq.size() != 0)); end
            checks++; if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%h exp=%h", c, in_ready, (mq.size() < 2)); end
            if (mq.size() != 0) begin
                h = mq[0];
                checks++; if (out_dnpc !== h.dnpc || out_err !== h.err || rf_waddr !== h.rd) begin errors++; $display("FAIL rnd_head c=%0d got dnpc=%h err=%h rd=%0d exp dnpc=%h err=%h rd=%0d", c, out_dnpc, out_err, rf_waddr, h.dnpc, h.err, h.rd); end
                checks++; if (rf_wen !== (out_ready && h.wen)) begin errors++; $display("FAIL rnd_wen c=%0d got=%h exp=%h", c, rf_wen, (out_ready && h.wen)); end
                if (h.wen) begin
                    checks++; if (rf_wdata !== h.wdata) begin errors++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, rf_wdata, h.wdata); end
                end
            end
`ifdef YSYX_25020047_WBU_RETCNT_EN
            checks++; if (retired_cnt !== ret_model) begin errors++; $display("FAIL rnd_retired c=%0d got=%0d exp=%0d", c, retired_cnt, ret_model); end
`endif
            clk_step();
        end
        drive_idle();
        out_ready = 1'b1;
        clk_step();
        clk_step();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        drive(3'd1, 32'hAA, 32'h0, 32'h4, 1'b0, 5'd2, 2'd0, 1'b0, 3'd0);
        clk_step();
        drive(3'd1, 32'hBB, 32'h0, 32'h8, 1'b0, 5'd3, 2'd0, 1'b0, 3'd0);
        clk_step();
        drive_idle();
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rstfull_pre got rdy=%h v=%h exp rdy=0 v=1", in_ready, out_valid); end
        rst_n = 1'b0;
        clk_step();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_post got v=%h rdy=%h exp v=0 rdy=1", out_valid, in_ready); end
`ifdef YSYX_25020047_WBU_RETCNT_EN
        checks++; if (retired_cnt !== 64'd0) begin errors++; $display("FAIL rstfull_retired got=%0d exp=0", retired_cnt); end
`endif
        clk_step();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_discard got=%h exp=0", out_valid); end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        ret_model = 64'd0;
        drive_idle();
        test_reset();
        test_alu();
        test_load();
        test_jump_branch();
        test_backpressure();
        test_errors();
        test_random();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_wbu_stage.md
# ysyx_25020047_wbu_stage

Pipelined, parametrised write-back stage for the NPC core, placed between EXU/LSU and the register file / IFU next-PC input. It accepts one completed instruction per cycle on a valid/ready handshake and selects write-back data and next PC from a compact op class. Load data is aligned and extended here. A 2-entry skid buffer ensures no combinational path runs from `out_ready` to `in_ready`.

## Interface
- `XLEN`, 32, datapath width (32 or 64)
- `RA_W`, 5, register address width
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous reset, active low
- `in_valid` / `in_ready`  in / out  1  upstream handshake; `in_ready` is a register output
- `in_wbsel`  in  3  op class: 0 NONE, 1 ALU, 2 LOAD, 3 JUMP, 4 BRANCH, 5–7 reserved
- `in_result`  in  XLEN  ALU result or branch/jump target
- `in_memdata`  in  XLEN  naturally aligned memory word
- `in_snpc`  in  XLEN  PC+4
- `in_taken`  in  1  branch taken; used only for BRANCH
- `in_rd`  in  RA_W  destination register
- `in_lsize`  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when XLEN=64)
- `in_lsign`  in  1  sign-extend load
- `in_addr_lo`  in  3  low address bits of the load
- `out_valid` / `out_ready`  out / in  1  commit handshake toward IFU
- `out_dnpc`  out  XLEN  next PC
- `out_err`  out  1  record was illegal (reserved class or misaligned load)
- `rf_wen`  out  1  register-file write strobe
- `rf_waddr`  out  RA_W  register-file write address
- `rf_wdata`  out  XLEN  register-file write data
- `retired_cnt`  out  64  retired-instruction count; present only with the macro

## Operation
- Enqueue on `in_valid & in_ready`. The record (wdata, dnpc, rd, wen, err) is computed combinationally at enqueue and stored.
- NONE: wen=0, dnpc=snpc.
- ALU: wdata=result, wen=1, dnpc=snpc.
- LOAD: wen=1, dnpc=snpc. Extract the byte/half/word at `in_addr_lo`, then zero- or sign-extend to XLEN.
- JUMP: wdata=snpc, wen=1, dnpc=result with bit0 forced to 0.
- BRANCH: wen=0, dnpc = taken ? result : snpc.
- Reserved class: wen=0, dnpc=snpc, err=1.
- Misaligned load: half with addr_lo[0]=1, word with addr_lo[1:0]≠0, dword with addr_lo≠0, or dword when XLEN=32. Result: wen=0, err=1, dnpc=snpc.
- rd=0 forces wen=0, with no error.
- The buffer is a FIFO of 2 entries; `count` ∈ {0,1,2}. Head drives `out_*`. `out_valid` = count≠0.
- Dequeue on `out_valid & out_ready`. `rf_wen` = dequeue & head.wen. `rf_waddr`/`rf_wdata` show the head whenever `out_valid`=1.
- `in_ready` = (count≠2), computed from registered state only.

## Timing
- Reset (synchronous, `rst_n`=0 at posedge): count=0, `in_ready`=1, `out_valid`=0, `out_dnpc`/`rf_waddr`/`rf_wdata`/`out_err`=0, `rf_wen`=0, `retired_cnt`=0. Buffered entries are discarded.
- Latency: a record accepted at edge N appears with `out_valid`=1 after edge N when count was 0.
- Sustained throughput is 1 record/cycle with `out_ready` held at 1.
- Simultaneous enqueue and dequeue: count is unchanged and order is preserved.
- count=2: `in_ready`=0, so no enqueue occurs even if a dequeue happens in the same cycle. `in_ready` returns to 1 the cycle after the dequeue.
- `out_*` must hold stable while `out_valid & !out_ready`.
- `in_*` are sampled only on an accepted handshake.

## Configuration
- `YSYX_25020047_WBU_RETCNT_EN` defined:
  - `retired_cnt` port exists.
  - It increments by 1 on every dequeue with `out_err`=0 and wraps at 2^64.
- `YSYX_25020047_WBU_RETCNT_EN` undefined:
  - The port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then ALU: result=0x1234, rd=5, out_ready=1 → next cycle `rf_wen`=1, waddr=5, wdata=0x1234, dnpc=snpc.
- LOAD: memdata=0x80FF_7F01, lsize=byte, lsign=1, addr_lo=2 → wdata=0xFFFF_FFFF. With addr_lo=1, lsign=0 → wdata=0x7F. Half with lsign=1, addr_lo=2 → wdata=0xFFFF_80FF.
- JUMP: result=0x8000_0103, snpc=0x8000_0010, rd=1 → dnpc=0x8000_0102, wdata=0x8000_0010. BRANCH with taken=0 → dnpc=snpc, `rf_wen`=0.
- Backpressure: out_ready=0, push 3 records → `in_ready` goes low after the 2nd and the 3rd is not accepted. Raise out_ready → records drain in order; `in_ready`=1 one cycle after the first dequeue.
- Errors: wbsel=6, then half load with addr_lo=3, then ALU with rd=0 → first two commit with `out_err`=1 and `rf_wen`=0; third commits with `rf_wen`=0 and `out_err`=0. With the macro, `retired_cnt` increases by 1.
- Assert `rst_n`=0 with count=2 → next cycle `out_valid`=0, `in_ready`=1, `retired_cnt`=0.
